mul_result_accum: RTL and testbench

Downstream consumer of the pipelined 4x4 multiplier's product stream. Sums consecutive valid products into one frame sum, closed by a last marker, which gives a dot-product style result. Completed sums queue in a small output FIFO with a valid/ready handshake. The multiplier cannot stall, so frames that complete while the FIFO is full are dropped and counted.

---
 rtl/mul_acc_pkg.sv | 41 ++++
 rtl/mul_result_accum_if.sv | 25 ++
 rtl/mul_acc_fifo.sv | 50 +++++
 rtl/mul_result_accum.sv | 107 ++++++++++
 tb/tb_mul_result_accum.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mul_acc_pkg.sv
// Shared types, default widths and saturating arithmetic for the product accumulator.
package mul_acc_pkg;

    localparam int PROD_W_DEF     = 8;
    localparam int ACC_W_DEF      = 16;
    localparam int CNT_W_DEF      = 8;
    localparam int FIFO_DEPTH_DEF = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_e;

    typedef struct packed {
        logic [ACC_W_DEF-1:0] sum;
        logic [CNT_W_DEF-1:0] cnt;
        logic                 sat;
    } fifo_entry_t;

    // Operands are w bits wide held in 32-bit containers; bit 32 of the result flags overflow.
    function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [32:0] s;
        logic [32:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        if (s > lim) begin
            return {1'b1, lim[31:0]};
        end
        return {1'b0, s[31:0]};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] a, input int w);
        logic [32:0] lim;
        lim = (33'd1 << w) - 33'd1;
        if ({1'b0, a} >= lim) begin
            return a;
        end
        return a + 32'd1;
    endfunction

endpackage

// File: rtl/mul_result_accum_if.sv
// Product stream in, completed frame sums out with a valid/ready handshake.
interface mul_result_accum_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 8
);
    logic [PROD_W-1:0] prod;
    logic              prod_vld;
    logic              prod_last;
    logic [ACC_W-1:0]  sum;
    logic [CNT_W-1:0]  sum_cnt;
    logic              sum_sat;
    logic              sum_vld;
    logic              sum_rdy;

    modport master (
        output prod, prod_vld, prod_last, sum_rdy,
        input  sum, sum_cnt, sum_sat, sum_vld
    );

    modport slave (
        input  prod, prod_vld, prod_last, sum_rdy,
        output sum, sum_cnt, sum_sat, sum_vld
    );
endinterface

// File: rtl/mul_acc_fifo.sv
// Small synchronous FIFO for completed frame sums; the head entry is read without a
// register stage so a push at edge N is visible right after edge N, never in the same cycle.
module mul_acc_fifo #(
    parameter int W     = 25,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr_reg;
    logic [AW:0]  rptr_reg;
    logic         do_push;
    logic         do_pop;

    // The extra pointer bit separates full from empty when the indices coincide.
    assign empty   = (wptr_reg == rptr_reg);
    assign full    = (wptr_reg[AW] != rptr_reg[AW]) && (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
        end else begin
            if (do_push) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (do_pop) begin
                rptr_reg <= rptr_reg + 1'b1;
            end
        end
    end
endmodule

// File: rtl/mul_result_accum.sv
// Accumulates multiplier products into per-frame sums and queues finished sums;
// frames closing against a full, non-draining queue are dropped and counted.
module mul_result_accum
    import mul_acc_pkg::*;
#(
    parameter int PROD_W     = PROD_W_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    mul_result_accum_if.slave        bus,
    output logic                     busy,
    output logic                     drop_err,
    output logic [7:0]               drop_cnt
);
    localparam int EW = ACC_W + CNT_W + 1;
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_ACC  = ACC;

    logic [0:0]       state_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             sat_reg;
    logic             drop_err_reg;
    logic [7:0]       drop_cnt_reg;

    logic [32:0]      add_res;
    logic [31:0]      inc_res;
    logic [ACC_W-1:0] sum_next;
    logic [CNT_W-1:0] cnt_next;
    logic             sat_next;
    logic             unused_bits;

    logic             push;
    logic             pop;
    logic             frame_drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [EW-1:0]    fifo_head;

    // acc/cnt/sat sit at zero in IDLE, so one adder path covers the first and later products.
    assign add_res     = sat_add(32'(acc_reg), 32'(bus.prod), ACC_W);
    assign inc_res     = sat_inc(32'(cnt_reg), CNT_W);
    assign sum_next    = add_res[ACC_W-1:0];
    assign cnt_next    = inc_res[CNT_W-1:0];
    assign sat_next    = sat_reg | add_res[32];
    assign unused_bits = ^{add_res[31:ACC_W], inc_res[31:CNT_W]};

    assign push       = bus.prod_vld && bus.prod_last;
    assign pop        = bus.sum_vld && bus.sum_rdy;
    assign frame_drop = push && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            sat_reg      <= 1'b0;
            drop_err_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            if (bus.prod_vld) begin
                if (bus.prod_last) begin
                    state_reg <= ST_IDLE;
                    acc_reg   <= '0;
                    cnt_reg   <= '0;
                    sat_reg   <= 1'b0;
                end else begin
                    state_reg <= ST_ACC;
                    acc_reg   <= sum_next;
                    cnt_reg   <= cnt_next;
                    sat_reg   <= sat_next;
                end
            end
            drop_err_reg <= frame_drop;
            if (frame_drop && (drop_cnt_reg != 8'hFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
        end
    end

    mul_acc_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   ({sum_next, cnt_next, sat_next}),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // Storage is not cleared on reset, so the outputs are forced to zero while empty.
    assign bus.sum_vld = !fifo_empty;
    assign bus.sum     = fifo_empty ? '0 : fifo_head[EW-1 -: ACC_W];
    assign bus.sum_cnt = fifo_empty ? '0 : fifo_head[CNT_W:1];
    assign bus.sum_sat = fifo_empty ? 1'b0 : fifo_head[0];

    assign busy     = (state_reg == ST_ACC);
    assign drop_err = drop_err_reg;
    assign drop_cnt = drop_cnt_reg;
endmodule

// File: tb/tb_mul_result_accum.sv
// Directed frames with hand-computed sums; a negedge monitor pops a scoreboard on each handshake.
module tb_mul_result_accum;
    import mul_acc_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       busy;
    logic       drop_err;
    logic [7:0] drop_cnt;

    int compared   = 0;
    int mismatched = 0;

    fifo_entry_t exp_q[$];
    fifo_entry_t exp_e;

    mul_result_accum_if #(.PROD_W(8), .ACC_W(16), .CNT_W(8)) bus ();

    mul_result_accum #(
        .PROD_W     (8),
        .ACC_W      (16),
        .CNT_W      (8),
        .FIFO_DEPTH (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .drop_err (drop_err),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic fifo_entry_t mk(input int s, input int c, input bit t);
        fifo_entry_t r;
        r.sum = 16'(s);
        r.cnt = 8'(c);
        r.sat = t;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic send(input int p, input bit last);
        bus.prod      = 8'(p);
        bus.prod_vld  = 1'b1;
        bus.prod_last = last;
        @(posedge clk);
        #1;
        bus.prod_vld  = 1'b0;
        bus.prod_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted head must match the oldest expected frame.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && bus.sum_vld && bus.sum_rdy) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_sum: got sum=%0d cnt=%0d sat=%0d required no output",
                             bus.sum, bus.sum_cnt, bus.sum_sat);
                end else begin
                    exp_e = exp_q.pop_front();
                    if (bus.sum !== exp_e.sum || bus.sum_cnt !== exp_e.cnt || bus.sum_sat !== exp_e.sat) begin
                        mismatched++;
                        $display("FAIL sum_entry: got sum=%0d cnt=%0d sat=%0d required sum=%0d cnt=%0d sat=%0d",
                                 bus.sum, bus.sum_cnt, bus.sum_sat, exp_e.sum, exp_e.cnt, exp_e.sat);
                    end else begin
                        $display("ok   sum_entry: sum=%0d cnt=%0d sat=%0d", bus.sum, bus.sum_cnt, bus.sum_sat);
                    end
                end
            end
        end
    end

    initial begin
        bus.prod      = '0;
        bus.prod_vld  = 1'b0;
        bus.prod_last = 1'b0;
        bus.sum_rdy   = 1'b0;
        reset         = 1'b0;
        idle(2);
        check("rst_sum_vld", int'(bus.sum_vld), 0);
        check("rst_sum", int'(bus.sum), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_drop_err", int'(drop_err), 0);
        check("rst_drop_cnt", int'(drop_cnt), 0);
        reset = 1'b1;
        idle(1);

        // Basic frame 3+5+7
        bus.sum_rdy = 1'b1;
        exp_q.push_back(mk(15, 3, 1'b0));
        send(3, 1'b0);
        check("basic_busy1", int'(busy), 1);
        send(5, 1'b0);
        check("basic_busy2", int'(busy), 1);
        send(7, 1'b1);
        check("basic_busy_end", int'(busy), 0);
        check("basic_vld", int'(bus.sum_vld), 1);
        idle(1);
        check("basic_vld_1cyc", int'(bus.sum_vld), 0);

        // Single-product frame followed immediately by a two-product frame
        exp_q.push_back(mk(9, 1, 1'b0));
        exp_q.push_back(mk(6, 2, 1'b0));
        send(9, 1'b1);
        check("single_busy", int'(busy), 0);
        send(2, 1'b0);
        send(4, 1'b1);
        idle(3);

        // Saturation: 300 x 225 overflows the sum and the count
        exp_q.push_back(mk(65535, 255, 1'b1));
        for (int i = 0; i < 299; i++) begin
            send(225, 1'b0);
        end
        send(225, 1'b1);
        idle(3);

        // Backpressure: third frame is dropped
        bus.sum_rdy = 1'b0;
        exp_q.push_back(mk(10, 1, 1'b0));
        exp_q.push_back(mk(20, 1, 1'b0));
        send(10, 1'b1);
        send(20, 1'b1);
        send(30, 1'b1);
        check("bp_drop_err", int'(drop_err), 1);
        check("bp_drop_cnt", int'(drop_cnt), 1);
        idle(1);
        check("bp_drop_err_pulse", int'(drop_err), 0);
        check("bp_head_stable", int'(bus.sum), 10);
        bus.sum_rdy = 1'b1;
        idle(3);
        check("bp_drained", int'(bus.sum_vld), 0);

        // Full queue with a pop on the same cycle a frame closes
        bus.sum_rdy = 1'b0;
        exp_q.push_back(mk(50, 1, 1'b0));
        exp_q.push_back(mk(60, 1, 1'b0));
        exp_q.push_back(mk(40, 1, 1'b0));
        send(50, 1'b1);
        send(60, 1'b1);
        bus.sum_rdy = 1'b1;
        send(40, 1'b1);
        check("fullpop_no_drop", int'(drop_err), 0);
        check("fullpop_drop_cnt", int'(drop_cnt), 1);
        idle(3);

        // Reset mid-frame with a sum already queued
        bus.sum_rdy = 1'b0;
        send(70, 1'b1);
        send(4, 1'b0);
        send(4, 1'b0);
        check("pre_rst_busy", int'(busy), 1);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        check("midrst_vld", int'(bus.sum_vld), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_drop_cnt", int'(drop_cnt), 0);
        bus.sum_rdy = 1'b1;
        exp_q.push_back(mk(9, 1, 1'b0));
        send(9, 1'b1);
        idle(3);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
